wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter that owns the register file's single write port (we/rd/Wdata) and merges two result sources: the single-cycle ALU path and the variable-latency load/store unit (LSU). ALU results always win the port. LSU results queue in a small in-order FIFO and drain on cycles when the ALU is not writing. The block exports a per-register pending mask so the hazard unit can stall reads of registers whose load data has not yet been written.

## Interface
- DEPTH, 4, LSU result FIFO entries (power of 2, ≥2)
- XLEN, 32, data width

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle (no back-pressure)
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  LSU result offered
- lsu_ready  out  1  FIFO can accept; transfer when lsu_valid && lsu_ready
- lsu_rd  in  5  LSU destination register
- lsu_data  in  XLEN  LSU result
- we  out  1  register file write enable (registered)
- rd  out  5  register file write address (registered)
- Wdata  out  XLEN  register file write data (registered)
- pending  out  32  bit r = 1 while a live FIFO entry targets x_r
- fifo_count  out  $clog2(DEPTH)+1  occupied entries, live and squashed

## Operation
- FIFO entry = {live, rd, data}, with write pointer, read pointer and count. Pointers wrap modulo DEPTH.
- Push: lsu_valid && lsu_ready && lsu_rd != 0. lsu_rd == 0 is accepted and discarded without enqueuing.
- lsu_ready = !rst && (count < DEPTH). A pop in the same cycle does not raise ready.
- ALU write is effective when alu_valid && alu_rd != 0. alu_rd == 0 counts as no ALU write.
- Per-cycle port select:
  - effective ALU write: we <= 1, rd <= alu_rd, Wdata <= alu_data.
  - else if count > 0: pop head. we <= head.live, rd <= head.rd, Wdata <= head.data.
  - else: we <= 0. rd and Wdata hold their values.
- WAW squash: an effective ALU write to register X clears `live` on every FIFO entry with rd == X. LSU results are always older than a concurrent ALU result, so the newer ALU value must never be overwritten.
  - A same-cycle incoming push with lsu_rd == X is enqueued with live = 0.
  - A squashed entry still occupies its slot. Its pop produces a cycle with we = 0.
- pending = OR over entries with live = 1 of onehot(rd). pending[0] is always 0. pending is combinational from FIFO state.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Reset: FIFO emptied and all live bits cleared. we = 0, rd = 0, Wdata = 0, pending = 0, fifo_count = 0, lsu_ready = 0 while rst is high.
  - Queued results are dropped on reset, including a reset that arrives mid-drain.
  - On the first cycle after rst deasserts, lsu_ready = 1.

## Timing
- ALU path: alu_valid sampled at edge E, we/rd/Wdata valid from E until edge E+1. Latency is 1 cycle.
- LSU path, FIFO empty and ALU idle:
  - Push at edge E.
  - Entry is head during cycle E..E+1 and pops at edge E+1.
  - we is asserted during E+1..E+2. Latency is 2 cycles.
- pending bit r rises in the cycle after the push edge. It falls in the cycle after the pop edge or the squash edge.
- Sustained alu_valid starves the FIFO. Once full, lsu_ready stays low until a non-ALU cycle pops.
- Throughput: one register file write per cycle at most.

## Test plan
- Reset check: hold rst 2 cycles with all inputs active -> we = 0, rd = 0, Wdata = 0, pending = 0, lsu_ready = 0. The cycle after release, lsu_ready = 1.
- ALU only: alu_valid, alu_rd = 5, alu_data = 0xDEADBEEF at edge E -> we = 1, rd = 5, Wdata = 0xDEADBEEF in the next cycle. alu_rd = 0 -> we = 0.
- LSU drain: push lsu_rd = 7, lsu_data = 0x1234 while ALU idle -> pending[7] = 1 one cycle later, then we = 1, rd = 7, Wdata = 0x1234 two cycles after the push. pending[7] returns to 0.
- Priority and fill: alu_valid held for 6 cycles while LSU offers rd = 1..6 every cycle (DEPTH = 4):
  - lsu_ready drops after 4 pushes; fifo_count = 4.
  - Once the ALU stops, writes to x1, x2, x3, x4 occur on consecutive cycles, then x5 and x6 after their pushes.
- WAW squash: push lsu_rd = 9, data = 0xAAAA, then at the next edge ALU writes x9 = 0xBBBB -> pending[9] = 0. The later pop yields we = 0, and the final x9 value is 0xBBBB.
- Same-cycle squash and wrap: with ALU writing x3, push lsu_rd = 3 in the same cycle -> the entry is enqueued dead and pending[3] stays 0. Run 3×DEPTH push/pop pairs -> pointers wrap and data order is preserved.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results own the register-file write port, LSU results queue in an in-order FIFO and drain on ALU-idle cycles.
// Latency: ALU 1 cycle, LSU 2 cycles when the FIFO is empty and the ALU is idle. Backpressure: lsu_ready low while the FIFO is full or in reset.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [4:0]               lsu_rd,
    input  logic [XLEN-1:0]          lsu_data,
    output logic                     we,
    output logic [4:0]               rd,
    output logic [XLEN-1:0]          Wdata,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic            live;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count;

    logic            alu_wr;
    logic            push;
    logic            pop;
    logic            push_dead;
    entry_t          head;

    always_comb begin
        alu_wr    = alu_valid && (alu_rd != 5'd0);
        lsu_ready = !rst && (count < DEPTH_C);
        push      = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
        pop       = !alu_wr && (count != '0);
        // An LSU result arriving alongside an ALU write to the same register is already stale.
        push_dead = alu_wr && (lsu_rd == alu_rd);
        head      = mem[rptr];
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].live) pending[mem[i].rd] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            we    <= 1'b0;
            rd    <= '0;
            Wdata <= '0;
        end else begin
            // WAW squash: older queued loads must never overwrite the newer ALU value.
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_wr && (mem[i].rd == alu_rd)) mem[i].live <= 1'b0;
            end

            // A popped slot is freed so it stops contributing to pending.
            if (pop) mem[rptr].live <= 1'b0;

            // Push never targets the head while a pop is active: pop needs count>0, push needs count<DEPTH.
            if (push) mem[wptr] <= '{live: !push_dead, rd: lsu_rd, data: lsu_data};

            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;

            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            if (alu_wr) begin
                we    <= 1'b1;
                rd    <= alu_rd;
                Wdata <= alu_data;
            end else if (pop) begin
                we    <= head.live;
                rd    <= head.rd;
                Wdata <= head.data;
            end else begin
                we    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, ALU path, LSU drain, priority/fill, WAW squash, reset mid-drain and pointer wrap.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] Wdata;
    logic [31:0] pending;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [32];

    wb_arbiter #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .we(we), .rd(rd), .Wdata(Wdata), .pending(pending), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Architectural register file as seen through the write port.
    always @(negedge clk) if (we) rf[rd] <= Wdata;

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1111_1111;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h2222_2222;
        tick; tick;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", we); end
        checks++; if (rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", rd); end
        checks++; if (Wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", Wdata); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending got %h want 0", pending); end
        checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", lsu_ready); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
        #1;
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", lsu_ready); end
        tick;
    endtask

    task automatic test_alu;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        tick;
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL alu_we got %b want 1", we); end
        checks++; if (rd !== 5'd5) begin errors++; $display("FAIL alu_rd got %0d want 5", rd); end
        checks++; if (Wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_wdata got %h want deadbeef", Wdata); end
        alu_rd = 5'd0; alu_data = 32'h5555_5555;
        tick;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL alu_x0_we got %b want 0", we); end
        checks++; if (Wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_x0_hold got %h want deadbeef", Wdata); end
        alu_valid = 1'b0;
        // LSU result to x0 is accepted but discarded.
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h6666_6666;
        #1;
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL lsu_x0_ready got %b want 1", lsu_ready); end
        tick;
        lsu_valid = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL lsu_x0_count got %0d want 0", fifo_count); end
        tick;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL lsu_x0_we got %b want 0", we); end
    endtask

    task automatic test_lsu_drain;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_1234;
        tick;
        lsu_valid = 1'b0;
        checks++; if (pending !== 32'h0000_0080) begin errors++; $display("FAIL drain_pending got %h want 00000080", pending); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL drain_count got %0d want 1", fifo_count); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL drain_early_we got %b want 0", we); end
        tick;
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL drain_we got %b want 1", we); end
        checks++; if (rd !== 5'd7) begin errors++; $display("FAIL drain_rd got %0d want 7", rd); end
        checks++; if (Wdata !== 32'h0000_1234) begin errors++; $display("FAIL drain_wdata got %h want 00001234", Wdata); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL drain_pending_clr got %h want 0", pending); end
    endtask

    task automatic test_priority_fill;
        int k;
        logic acc;
        k = 1;
        for (int i = 1; i <= 6; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'(i * 256);
            lsu_valid = 1'b1; lsu_rd = 5'(k); lsu_data = 32'h1000 + 32'(k);
            #1;
            acc = lsu_ready;
            tick;
            if (acc) k++;
            checks++; if (we !== 1'b1 || rd !== 5'(10 + i)) begin errors++; $display("FAIL prio_alu%0d got we=%b rd=%0d want we=1 rd=%0d", i, we, rd, 10 + i); end
        end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", fifo_count); end
        checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b want 0", lsu_ready); end
        checks++; if (pending !== 32'h0000_001E) begin errors++; $display("FAIL fill_pending got %h want 0000001e", pending); end
        checks++; if (k !== 5) begin errors++; $display("FAIL fill_accepted got %0d want 4", k - 1); end
        alu_valid = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            lsu_valid = (k <= 6); lsu_rd = 5'(k); lsu_data = 32'h1000 + 32'(k);
            #1;
            acc = lsu_valid && lsu_ready;
            tick;
            if (acc) k++;
            checks++; if (we !== 1'b1 || rd !== 5'(j) || Wdata !== 32'h1000 + 32'(j)) begin errors++; $display("FAIL drain_order%0d got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h", j, we, rd, Wdata, j, 32'h1000 + j); end
        end
        lsu_valid = 1'b0;
        checks++; if (fifo_count !== 3'd0 || pending !== 32'h0) begin errors++; $display("FAIL fill_empty got count=%0d pending=%h want 0/0", fifo_count, pending); end
    endtask

    task automatic test_waw_squash;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h0000_AAAA;
        tick;
        lsu_valid = 1'b0;
        checks++; if (pending !== 32'h0000_0200) begin errors++; $display("FAIL waw_pending_set got %h want 00000200", pending); end
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_BBBB;
        tick;
        alu_valid = 1'b0;
        checks++; if (we !== 1'b1 || rd !== 5'd9 || Wdata !== 32'h0000_BBBB) begin errors++; $display("FAIL waw_alu got we=%b rd=%0d data=%h want 1/9/0000bbbb", we, rd, Wdata); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL waw_pending_clr got %h want 0", pending); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL waw_count got %0d want 1", fifo_count); end
        tick;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL waw_dead_pop_we got %b want 0", we); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL waw_dead_pop_count got %0d want 0", fifo_count); end
        tick;
        checks++; if (rf[9] !== 32'h0000_BBBB) begin errors++; $display("FAIL waw_final_x9 got %h want 0000bbbb", rf[9]); end
    endtask

    task automatic test_same_cycle_squash;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_3333;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h0000_4444;
        tick;
        alu_valid = 1'b0; lsu_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL same_count got %0d want 1", fifo_count); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL same_pending got %h want 0", pending); end
        checks++; if (we !== 1'b1 || Wdata !== 32'h0000_3333) begin errors++; $display("FAIL same_alu got we=%b data=%h want 1/00003333", we, Wdata); end
        tick;
        checks++; if (we !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL same_dead_pop got we=%b count=%0d want 0/0", we, fifo_count); end
    endtask

    task automatic test_reset_mid_drain;
        lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h0000_0020;
        tick;
        lsu_rd = 5'd21; lsu_data = 32'h0000_0021;
        alu_valid = 1'b1; alu_rd = 5'd30; alu_data = 32'h0000_0030;
        tick;
        lsu_valid = 1'b0; alu_valid = 1'b0;
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL mid_count got %0d want 2", fifo_count); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if (fifo_count !== 3'd0 || pending !== 32'h0 || we !== 1'b0) begin errors++; $display("FAIL mid_reset got count=%0d pending=%h we=%b want 0/0/0", fifo_count, pending, we); end
        tick;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL mid_no_drain got we=%b want 0", we); end
    endtask

    task automatic test_back_to_back_wrap;
        lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h0000_C000;
        tick;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL wrap_first_count got %0d want 1", fifo_count); end
        for (int i = 1; i < 12; i++) begin
            lsu_rd = 5'(i + 1); lsu_data = 32'h0000_C000 + 32'(i);
            tick;
            checks++; if (we !== 1'b1 || rd !== 5'(i) || Wdata !== 32'h0000_C000 + 32'(i - 1) || fifo_count !== 3'd1) begin errors++; $display("FAIL wrap%0d got we=%b rd=%0d data=%h count=%0d want 1/%0d/%h/1", i, we, rd, Wdata, fifo_count, i, 32'hC000 + i - 1); end
        end
        lsu_valid = 1'b0;
        tick;
        checks++; if (we !== 1'b1 || rd !== 5'd12 || Wdata !== 32'h0000_C00B || fifo_count !== 3'd0) begin errors++; $display("FAIL wrap_last got we=%b rd=%0d data=%h count=%0d want 1/12/0000c00b/0", we, rd, Wdata, fifo_count); end
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        test_reset;
        test_alu;
        test_lsu_drain;
        test_priority_fill;
        test_waw_squash;
        test_same_cycle_squash;
        test_reset_mid_drain;
        test_back_to_back_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
